// File: rtl/mult_mac.sv
// mult_mac -- iterative radix-2 shift-add multiplier with an optional
// accumulator.
//
// One start request captures both operands, the signed/unsigned mode and the
// accumulate flag. The block then runs one shift-add step per multiplier bit,
// for in_width steps. One more edge forms the final product and enters DONE.
// It stays in DONE until the start request is released.
//
// Parameters
//   in_width    operand width (2..32)
//   guard_bits  accumulator headroom above the product width (0..16)
//
// Ports
//   clk                rising-edge clock
//   rst                asynchronous active-high reset
//   data_multiplicand  operand A
//   data_multiplier    operand B
//   ctrl_signed        1 = two's-complement operands, 0 = unsigned
//   ctrl_accumulate    1 = add the product into data_acc on completion
//   ctrl_clear         zero data_acc / ctrl_overflow (IDLE only)
//   ctrl_enable        level start request, held until ctrl_done is seen
//   data_result        product of the last completed operation
//   data_acc           running accumulator
//   ctrl_done          result valid, high throughout DONE
//   ctrl_busy          high throughout CALC
//   ctrl_overflow      sticky accumulator overflow flag
module mult_mac #(
    parameter int in_width   = 8,
    parameter int guard_bits = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [in_width-1:0]                 data_multiplicand,
    input  logic [in_width-1:0]                 data_multiplier,
    input  logic                                ctrl_signed,
    input  logic                                ctrl_accumulate,
    input  logic                                ctrl_clear,
    input  logic                                ctrl_enable,
    output logic [2*in_width-1:0]               data_result,
    output logic [2*in_width+guard_bits-1:0]    data_acc,
    output logic                                ctrl_done,
    output logic                                ctrl_busy,
    output logic                                ctrl_overflow
);

    localparam int out_width = 2 * in_width;
    localparam int acc_width = out_width + guard_bits;
    localparam int cnt_width = $clog2(in_width + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [cnt_width-1:0] last_step = cnt_width'(in_width);

    logic [1:0]           state;
    logic [out_width-1:0] mcand_sh;
    logic [in_width-1:0]  mplier_sh;
    logic [out_width-1:0] partial;
    logic [cnt_width-1:0] step;
    logic                 negate;
    logic                 signed_q;
    logic                 accumulate_q;

    logic [out_width-1:0] product;
    logic [acc_width-1:0] addend;
    logic [acc_width:0]   sum;
    logic                 add_ovf;

    // The most negative operand has magnitude 2^(in_width-1). That value
    // still fits in in_width unsigned bits, so the product is exact.
    function automatic logic [in_width-1:0] magnitude(
        input logic [in_width-1:0] v,
        input logic                sgn
    );
        if (sgn && v[in_width-1])
            return -v;
        else
            return v;
    endfunction

    function automatic logic [acc_width-1:0] extend(
        input logic [out_width-1:0] p,
        input logic                 sgn
    );
        return sgn ? acc_width'($signed(p)) : acc_width'(p);
    endfunction

    always_comb begin
        product = negate ? -partial : partial;
        addend  = extend(product, signed_q);
        sum     = {1'b0, data_acc} + {1'b0, addend};
        // Signed overflow: both operands have the same sign, but the sum's
        // sign differs. Unsigned overflow: carry out of the top bit.
        if (signed_q)
            add_ovf = (data_acc[acc_width-1] == addend[acc_width-1]) &&
                      (sum[acc_width-1] != data_acc[acc_width-1]);
        else
            add_ovf = sum[acc_width];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mcand_sh      <= '0;
            mplier_sh     <= '0;
            partial       <= '0;
            step          <= '0;
            negate        <= 1'b0;
            signed_q      <= 1'b0;
            accumulate_q  <= 1'b0;
            data_result   <= '0;
            data_acc      <= '0;
            ctrl_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl_clear) begin
                        data_acc      <= '0;
                        ctrl_overflow <= 1'b0;
                    end
                    if (ctrl_enable) begin
                        mcand_sh     <= out_width'(magnitude(data_multiplicand, ctrl_signed));
                        mplier_sh    <= magnitude(data_multiplier, ctrl_signed);
                        partial      <= '0;
                        step         <= '0;
                        negate       <= ctrl_signed &
                                        (data_multiplicand[in_width-1] ^ data_multiplier[in_width-1]);
                        signed_q     <= ctrl_signed;
                        accumulate_q <= ctrl_accumulate;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    if (step == last_step) begin
                        // All multiplier bits consumed: publish and accumulate
                        data_result <= product;
                        if (accumulate_q) begin
                            data_acc <= sum[acc_width-1:0];
                            if (add_ovf)
                                ctrl_overflow <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        if (mplier_sh[0])
                            partial <= partial + mcand_sh;
                        mcand_sh  <= mcand_sh << 1;
                        mplier_sh <= mplier_sh >> 1;
                        step      <= step + cnt_width'(1);
                    end
                end
                DONE: begin
                    if (!ctrl_enable)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ctrl_done = (state == DONE);
        ctrl_busy = (state == CALC);
    end

endmodule

// File: tb/tb_mult_mac.sv
// tb_mult_mac -- bench for mult_mac.
//
// Two instances share all inputs. Both use in_width=4. One uses guard_bits=4
// and the other guard_bits=0. Expected values come from integer arithmetic on
// the captured operands. Directed cases are followed by a randomized sequence.
module tb_mult_mac;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic         sgn, accum, clr, en;

    logic [7:0]  res0, res1;
    logic [11:0] acc0;
    logic [7:0]  acc1;
    logic        done0, busy0, ov0, done1, busy1, ov1;

    mult_mac #(.in_width(W), .guard_bits(4)) u_g4 (
        .clk(clk), .rst(rst),
        .data_multiplicand(a), .data_multiplier(b),
        .ctrl_signed(sgn), .ctrl_accumulate(accum), .ctrl_clear(clr), .ctrl_enable(en),
        .data_result(res0), .data_acc(acc0),
        .ctrl_done(done0), .ctrl_busy(busy0), .ctrl_overflow(ov0)
    );

    mult_mac #(.in_width(W), .guard_bits(0)) u_g0 (
        .clk(clk), .rst(rst),
        .data_multiplicand(a), .data_multiplier(b),
        .ctrl_signed(sgn), .ctrl_accumulate(accum), .ctrl_clear(clr), .ctrl_enable(en),
        .data_result(res1), .data_acc(acc1),
        .ctrl_done(done1), .ctrl_busy(busy1), .ctrl_overflow(ov1)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference state
    logic [7:0] m_res;
    longint     m_acc0, m_acc1;
    bit         m_ov0, m_ov1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Add product p into an accumulator of width w. The value is kept as an
    // unsigned residue; overflow is judged in the mode of the operation.
    function automatic void acc_step(input int w, input bit s, input longint p,
                                     inout longint acc, inout bit ov);
        longint lim, av, sum;
        lim = longint'(1) << w;
        if (s) begin
            av  = (acc >= lim / 2) ? acc - lim : acc;
            sum = av + p;
            if (sum < -(lim / 2) || sum >= lim / 2) ov = 1'b1;
        end else begin
            sum = acc + p;
            if (sum >= lim) ov = 1'b1;
        end
        acc = ((sum % lim) + lim) % lim;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_res0"}, res0, m_res);
        check({tag, "_res1"}, res1, m_res);
        check({tag, "_acc0"}, acc0, 32'(m_acc0));
        check({tag, "_ov0"},  ov0,  m_ov0);
        check({tag, "_acc1"}, acc1, 32'(m_acc1));
        check({tag, "_ov1"},  ov1,  m_ov1);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input bit ts, input bit tacc, input bit tclr, input string tag);
        int va, vb, p;
        bit timing_ok, hold_ok;
        @(negedge clk);
        a = ta; b = tb_v; sgn = ts; accum = tacc; clr = tclr; en = 1'b1;
        @(posedge clk);
        if (tclr) begin
            m_acc0 = 0; m_acc1 = 0; m_ov0 = 0; m_ov1 = 0;
        end
        va = (ts && ta[W-1]) ? int'(ta) - 16 : int'(ta);
        vb = (ts && tb_v[W-1]) ? int'(tb_v) - 16 : int'(tb_v);
        p  = va * vb;
        m_res = 8'(p);
        if (tacc) begin
            acc_step(12, ts, longint'(p), m_acc0, m_ov0);
            acc_step(8,  ts, longint'(p), m_acc1, m_ov1);
        end
        // Busy for in_width+1 cycles after capture; inputs are scrambled
        timing_ok = 1'b1;
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            if (!(busy0 === 1'b1 && done0 === 1'b0 && busy1 === 1'b1 && done1 === 1'b0))
                timing_ok = 1'b0;
            a = 4'($urandom); b = 4'($urandom);
            sgn = 1'($urandom); accum = 1'($urandom); clr = 1'($urandom);
        end
        @(negedge clk);
        check({tag, "_busy_window"}, timing_ok, 1'b1);
        check({tag, "_done"}, {done0, busy0, done1, busy1}, 4'b1010);
        check_state(tag);
        // Enable still high: must stay in DONE without restarting
        hold_ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
            clr = 1'($urandom);
            @(negedge clk);
            if (!(done0 === 1'b1 && busy0 === 1'b0 && done1 === 1'b1)) hold_ok = 1'b0;
        end
        check({tag, "_hold"}, hold_ok, 1'b1);
        en = 1'b0; clr = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, {done0, busy0, done1, busy1}, 4'b0000);
        check({tag, "_res_kept"}, res0, m_res);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        en = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_acc0 = 0; m_acc1 = 0; m_ov0 = 0; m_ov1 = 0;
        check({tag, "_acc0"}, acc0, 32'd0);
        check({tag, "_ov0"},  ov0,  1'b0);
        check({tag, "_acc1"}, acc1, 32'd0);
        check({tag, "_ov1"},  ov1,  1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; a = '0; b = '0; sgn = 1'b0; accum = 1'b0; clr = 1'b0; en = 1'b0;
        m_res = 0; m_acc0 = 0; m_acc1 = 0; m_ov0 = 0; m_ov1 = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_flags", {done0, busy0, ov0, done1, busy1, ov1}, 6'b0);
        check_state("reset");
        rst = 1'b0;

        // Basic unsigned and signed products
        run_op(4'd7, 4'd5, 1'b0, 1'b0, 1'b0, "u7x5");
        check("u7x5_lit", res0, 8'd35);
        run_op(4'b1101, 4'b0101, 1'b1, 1'b0, 1'b0, "sm3x5");
        check("sm3x5_lit", res0, 8'hF1);
        run_op(4'd8, 4'd8, 1'b1, 1'b0, 1'b0, "sm8xm8");
        check("sm8xm8_lit", res1, 8'h40);
        run_op(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, "u15x15");
        check("u15x15_lit", res0, 8'hE1);

        // Accumulation, then a non-accumulating op
        do_clear("clr1");
        run_op(4'd7, 4'd5, 1'b0, 1'b1, 1'b0, "acc7x5");
        run_op(4'd3, 4'd2, 1'b0, 1'b1, 1'b0, "acc3x2");
        check("acc41_g4", acc0, 32'd41);
        run_op(4'd2, 4'd2, 1'b0, 1'b0, 1'b0, "noacc2x2");
        check("acc41_kept", acc0, 32'd41);
        check("res4_lit", res0, 8'd4);

        // Unsigned overflow with no guard bits
        do_clear("clr2");
        run_op(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, "ovf_a");
        run_op(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, "ovf_b");
        check("acc194_g0", acc1, 32'd194);
        check("ovf_g0", ov1, 1'b1);
        check("acc450_g4", acc0, 32'd450);
        check("noovf_g4", ov0, 1'b0);
        do_clear("clr3");

        // Clear and start on the same edge
        run_op(4'd5, 4'd6, 1'b0, 1'b1, 1'b0, "pre_clr");
        run_op(4'd3, 4'd3, 1'b0, 1'b1, 1'b1, "clr_start");
        check("clr_start_lit", acc0, 32'd9);

        // Reset during CALC
        @(negedge clk);
        a = 4'd9; b = 4'd7; sgn = 1'b0; accum = 1'b1; en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        m_res = 0; m_acc0 = 0; m_acc1 = 0; m_ov0 = 0; m_ov1 = 0;
        check("midrst_flags", {done0, busy0, ov0, done1, busy1, ov1}, 6'b0);
        check_state("midrst");
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        run_op(4'd6, 4'd6, 1'b0, 1'b0, 1'b0, "post_rst");
        check("post_rst_lit", res0, 8'd36);

        // Randomized operations against the reference
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0), "rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_mac.md
MULT_MAC -- requirements
Module: mult_mac

Interface
REQ-001 Parameter in_width, default 8: operand width in bits, legal range 2..32.
REQ-002 Parameter guard_bits, default 4: extra accumulator bits above the product width, legal range 0..16.
REQ-003 Derived widths: out_width = 2*in_width; acc_width = out_width + guard_bits.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 data_multiplicand  input  in_width  operand A.
REQ-007 data_multiplier  input  in_width  operand B.
REQ-008 ctrl_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 ctrl_accumulate  input  1  1 = add the product into data_acc on completion.
REQ-010 ctrl_clear  input  1  clears data_acc and ctrl_overflow, honoured in IDLE only.
REQ-011 ctrl_enable  input  1  level start request, held high until ctrl_done is seen.
REQ-012 data_result  output  out_width  product of the last completed operation.
REQ-013 data_acc  output  acc_width  running accumulator.
REQ-014 ctrl_done  output  1  result valid; held high while in DONE.
REQ-015 ctrl_busy  output  1  high while in CALC.
REQ-016 ctrl_overflow  output  1  sticky accumulator overflow flag.

Function
REQ-017 The FSM shall have three states, IDLE, CALC and DONE, and shall reset to IDLE.
REQ-018 IDLE -> CALC on a clock edge with ctrl_enable=1; that edge captures both operands, ctrl_signed and ctrl_accumulate.
REQ-019 Input changes after the capture edge shall be ignored until the block returns to IDLE.
REQ-020 CALC shall be iterative radix-2 shift-add, one multiplier bit per cycle, using exactly in_width cycles with no early termination.
REQ-021 Signed mode shall multiply operand magnitudes and negate the result when the operand signs differ.
REQ-022 Products shall be exact at out_width with no truncation, including signed -2^(in_width-1) * -2^(in_width-1) = +2^(2*in_width-2).
REQ-023 CALC -> DONE exactly in_width+1 edges after the capture edge; ctrl_done=1 and data_result valid in the same cycle.
REQ-024 data_result shall hold its value from DONE until the next DONE entry; ctrl_busy=1 only in CALC.
REQ-025 On the edge entering DONE, if ctrl_accumulate was captured, data_acc += the product extended to acc_width (sign-extended in signed mode, zero-extended otherwise), wrapping modulo 2^acc_width.
REQ-026 ctrl_overflow shall set on that add on unsigned carry-out (unsigned mode) or signed overflow (signed mode), and shall stay set until a clear or reset.
REQ-027 Operations with ctrl_accumulate=0 shall leave data_acc and ctrl_overflow unchanged.
REQ-028 DONE -> IDLE on the first edge with ctrl_enable=0; ctrl_done deasserts in the same transition.
REQ-029 If ctrl_enable stays high in DONE, the block shall remain in DONE and shall not restart.
REQ-030 In IDLE, ctrl_clear=1 zeroes data_acc and ctrl_overflow on the edge.
REQ-031 If ctrl_clear and ctrl_enable are both high in IDLE, the clear and the capture happen on the same edge, so a later accumulate adds to zero.
REQ-032 ctrl_clear shall be ignored in CALC and DONE.

Reset
REQ-033 rst=1 shall immediately force IDLE and zero data_result, data_acc, ctrl_done, ctrl_busy, ctrl_overflow and all internal registers, including mid-CALC.
REQ-034 After rst falls, the block shall accept a new start on the first edge with ctrl_enable=1.

Verification
REQ-035 in_width=4, unsigned, 7*5 -> ctrl_done on the 5th edge after capture, data_result=35, ctrl_done held until ctrl_enable drops, then low the next edge.
REQ-036 in_width=4, signed: 4'b1101*4'b0101 -> 8'hF1 (-15); -8*-8 -> 8'h40; unsigned 15*15 -> 8'hE1.
REQ-037 in_width=4, guard_bits=4: clear, then accumulate 7*5 and 3*2 -> data_acc=41; a following non-accumulate 2*2 leaves data_acc=41 and sets data_result=4.
REQ-038 in_width=4, guard_bits=0, unsigned: accumulate 15*15 twice -> data_acc=194, ctrl_overflow=1; ctrl_clear in IDLE -> both 0.
REQ-039 Assert rst during CALC cycle 2 -> all outputs 0 immediately; a subsequent 6*6 -> data_result=36.
REQ-040 Change operands and ctrl_signed during CALC -> result matches the captured values; ctrl_clear during CALC leaves data_acc unchanged.
